// File: rtl/bm_seq_pkg.sv
// Shared definitions for the bitmap transfer sequencer: sizes, counter
// width, the last word index and the FSM state encoding.
package bm_seq_pkg;

    localparam int BM_WORDS = 96;
    localparam int BM_WIDTH = 1536;
    localparam int WORD_W   = 16;
    localparam int CNT_W    = 7;

    localparam logic [CNT_W-1:0] LAST_CNT = 7'(BM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD,
        S_LD_LAST,
        S_WR_BM,
        S_ST
    } state_t;

endpackage

// File: rtl/bm_xfer_buf.sv
// Bitmap transfer buffer: one 1536-bit register that can be captured whole
// from the bitmap register file, written one 16-bit word at a time from
// memory, and read one word at a time for memory stores.
module bm_xfer_buf
    import bm_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_capture,
    input  logic [BM_WIDTH-1:0] i_cap_data,
    input  logic                i_wr_en,
    input  logic [CNT_W-1:0]    i_wr_idx,
    input  logic [WORD_W-1:0]   i_wr_data,
    input  logic [CNT_W-1:0]    i_rd_idx,
    output logic [WORD_W-1:0]   o_rd_word,
    output logic [BM_WIDTH-1:0] o_buf
);

    logic [BM_WIDTH-1:0] r_buf;

    // Whole-bitmap capture takes precedence over a single-word update; the
    // FSM never requests both in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf <= '0;
        end else if (i_capture) begin
            r_buf <= i_cap_data;
        end else if (i_wr_en) begin
            r_buf[{i_wr_idx, 4'b0000} +: WORD_W] <= i_wr_data;
        end
    end

    assign o_rd_word = r_buf[{i_rd_idx, 4'b0000} +: WORD_W];
    assign o_buf     = r_buf;

endmodule

// File: rtl/bm_xfer_seq.sv
// Bitmap load/store sequencer. A load (LDB) reads 96 consecutive memory
// words into the transfer buffer and then writes the buffer to a bitmap
// register; a store (STB) captures a bitmap register and writes it out as
// 96 consecutive memory words. Addresses wrap modulo 2^16.
module bm_xfer_seq
    import bm_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start_ld,
    input  logic                start_st,
    input  logic [1:0]          bm_sel,
    input  logic [15:0]         base_addr,
    output logic [15:0]         mem_addr,
    output logic                mem_en,
    output logic                mem_wr,
    output logic [15:0]         mem_wdata,
    input  logic [15:0]         mem_rdata,
    output logic [1:0]          rbm_addr,
    input  logic [BM_WIDTH-1:0] rbm_data,
    output logic [1:0]          wbm_addr,
    output logic [BM_WIDTH-1:0] wbm_data,
    output logic                wbm_en,
    output logic                busy,
    output logic                done
);

    state_t             r_state;
    state_t             w_nextState;
    logic [CNT_W-1:0]   r_cnt;
    logic [15:0]        r_base;
    logic [1:0]         r_sel;
    logic               w_accept;
    logic [15:0]        w_addr;
    logic               w_bufCapture;
    logic               w_bufWrEn;
    logic [CNT_W-1:0]   w_bufWrIdx;
    logic [WORD_W-1:0]  w_rdWord;

    assign w_accept = (r_state == S_IDLE) && (start_ld || start_st);
    assign w_addr   = r_base + {9'd0, r_cnt};

    bm_xfer_buf u_buf (
        .clk        (clk),
        .rst        (rst),
        .i_capture  (w_bufCapture),
        .i_cap_data (rbm_data),
        .i_wr_en    (w_bufWrEn),
        .i_wr_idx   (w_bufWrIdx),
        .i_wr_data  (mem_rdata),
        .i_rd_idx   (r_cnt),
        .o_rd_word  (w_rdWord),
        .o_buf      (wbm_data)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Latch operands on an accepted start and step the word counter while
    // issuing memory requests; the counter returns to 0 after word 95.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_base <= '0;
            r_sel  <= '0;
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_base <= base_addr;
            r_sel  <= bm_sel;
        end else if ((r_state == S_LD) || (r_state == S_ST)) begin
            r_cnt  <= (r_cnt == LAST_CNT) ? '0 : r_cnt + 7'd1;
        end
    end

    // Next-state and output decode. Read data arrives one cycle after its
    // request, so in LD the word written is the one issued last cycle and
    // LD_LAST exists only to absorb word 95.
    always_comb begin
        w_nextState  = r_state;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        wbm_en       = 1'b0;
        wbm_addr     = '0;
        done         = 1'b0;
        busy         = 1'b1;
        rbm_addr     = r_sel;
        w_bufCapture = 1'b0;
        w_bufWrEn    = 1'b0;
        w_bufWrIdx   = r_cnt - 7'd1;
        case (r_state)
            S_IDLE: begin
                busy     = 1'b0;
                rbm_addr = bm_sel;
                if (start_ld) begin
                    w_nextState = S_LD;
                end else if (start_st) begin
                    w_nextState  = S_ST;
                    w_bufCapture = 1'b1;
                end
            end
            S_LD: begin
                mem_en    = 1'b1;
                mem_addr  = w_addr;
                w_bufWrEn = (r_cnt != '0);
                if (r_cnt == LAST_CNT) begin
                    w_nextState = S_LD_LAST;
                end
            end
            S_LD_LAST: begin
                w_bufWrEn   = 1'b1;
                w_bufWrIdx  = LAST_CNT;
                w_nextState = S_WR_BM;
            end
            S_WR_BM: begin
                wbm_en      = 1'b1;
                wbm_addr    = r_sel;
                done        = 1'b1;
                w_nextState = S_IDLE;
            end
            S_ST: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = w_addr;
                mem_wdata = w_rdWord;
                if (r_cnt == LAST_CNT) begin
                    done        = 1'b1;
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bm_xfer_seq.sv
// Scoreboard bench for bm_xfer_seq: stimulus pushes the expected memory
// requests and bitmap writes (with the cycle each must appear on) and a
// negedge monitor pops and compares every active output cycle.
module tb_bm_xfer_seq;
    import bm_seq_pkg::*;

    localparam int K_RD   = 1;
    localparam int K_WR   = 2;
    localparam int K_WBM  = 3;
    localparam int K_DONE = 4;

    typedef struct {
        int                  kind;
        logic [15:0]         addr;
        logic [15:0]         data;
        logic [BM_WIDTH-1:0] bm;
        logic                done;
        int                  cyc;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                start_ld;
    logic                start_st;
    logic [1:0]          bm_sel;
    logic [15:0]         base_addr;
    logic [15:0]         mem_addr;
    logic                mem_en;
    logic                mem_wr;
    logic [15:0]         mem_wdata;
    logic [15:0]         mem_rdata = '0;
    logic [1:0]          rbm_addr;
    logic [BM_WIDTH-1:0] rbm_data;
    logic [1:0]          wbm_addr;
    logic [BM_WIDTH-1:0] wbm_data;
    logic                wbm_en;
    logic                busy;
    logic                done;

    logic [BM_WIDTH-1:0] bmFile [4];
    logic [15:0]         loadBase = '0;
    int                  cycleCnt = 0;
    int                  checks   = 0;
    int                  fails    = 0;
    exp_t                expQ [$];

    exp_t                monExp;
    int                  monKind;
    logic [15:0]         monAddr;
    logic                monOk;

    bm_xfer_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start_ld  (start_ld),
        .start_st  (start_st),
        .bm_sel    (bm_sel),
        .base_addr (base_addr),
        .mem_addr  (mem_addr),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .rbm_addr  (rbm_addr),
        .rbm_data  (rbm_data),
        .wbm_addr  (wbm_addr),
        .wbm_data  (wbm_data),
        .wbm_en    (wbm_en),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Cycle counter; read only at negedges, so always stable when used.
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Memory model: word i of the current load region holds 0x1000+i,
    // returned the cycle after the read request.
    always @(posedge clk) begin
        if (mem_en && !mem_wr) mem_rdata <= 16'h1000 + (mem_addr - loadBase);
    end

    // Bitmap register file model with combinational read.
    assign rbm_data = bmFile[rbm_addr];

    function automatic logic [BM_WIDTH-1:0] expLoadVec();
        logic [BM_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < BM_WORDS; i++) v[i*16 +: 16] = 16'h1000 + 16'(i);
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            fails++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic pushLoad(input int p, input logic [1:0] sel, input logic [15:0] base);
        exp_t e;
        for (int i = 0; i < BM_WORDS; i++) begin
            e.kind = K_RD;
            e.addr = base + 16'(i);
            e.data = '0;
            e.bm   = '0;
            e.done = 1'b0;
            e.cyc  = p + i + 1;
            expQ.push_back(e);
        end
        e.kind = K_WBM;
        e.addr = {14'd0, sel};
        e.data = '0;
        e.bm   = expLoadVec();
        e.done = 1'b1;
        e.cyc  = p + 98;
        expQ.push_back(e);
    endtask

    task automatic pushStore(input int p, input logic [1:0] sel, input logic [15:0] base);
        exp_t e;
        for (int i = 0; i < BM_WORDS; i++) begin
            e.kind = K_WR;
            e.addr = base + 16'(i);
            e.data = bmFile[sel][i*16 +: 16];
            e.bm   = '0;
            e.done = (i == BM_WORDS - 1);
            e.cyc  = p + i + 1;
            expQ.push_back(e);
        end
    endtask

    // Drive a start for one cycle; the load request wins if both are set.
    task automatic applyStimulus(input logic ld, input logic st, input logic [1:0] sel,
                                 input logic [15:0] base, output int p);
        @(negedge clk);
        p         = cycleCnt;
        start_ld  = ld;
        start_st  = st;
        bm_sel    = sel;
        base_addr = base;
        if (ld) begin
            loadBase = base;
            pushLoad(p, sel, base);
        end else if (st) begin
            pushStore(p, sel, base);
        end
        @(negedge clk);
        start_ld = 1'b0;
        start_st = 1'b0;
    endtask

    task automatic waitIdle(input int p, input int last, input string name);
        while (cycleCnt < p + last + 1) @(negedge clk);
        checkOutput({name, "BusyLow"}, {31'd0, busy}, 32'd0);
        checkOutput({name, "QEmpty"}, expQ.size(), 32'd0);
    endtask

    // Monitor: every cycle with a memory request, bitmap write or done must
    // match the next expected event, including the cycle it occurs on.
    always @(negedge clk) begin
        if (mem_en || wbm_en || done) begin
            if (wbm_en)                monKind = K_WBM;
            else if (mem_en && mem_wr) monKind = K_WR;
            else if (mem_en)           monKind = K_RD;
            else                       monKind = K_DONE;
            monAddr = wbm_en ? {14'd0, wbm_addr} : mem_addr;
            checks++;
            if (expQ.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected event: got kind=%0d addr=%h done=%b cycle=%0d, want none",
                         monKind, monAddr, done, cycleCnt);
            end else begin
                monExp = expQ.pop_front();
                monOk  = (monKind == monExp.kind) && (monAddr == monExp.addr) &&
                         (done == monExp.done) && (cycleCnt == monExp.cyc) &&
                         !(wbm_en && mem_en);
                if (monKind == K_WR)  monOk = monOk && (mem_wdata == monExp.data);
                if (monKind == K_WBM) monOk = monOk && (wbm_data == monExp.bm);
                if (!monOk) begin
                    fails++;
                    $display("[TB] FAIL sb event: got kind=%0d addr=%h wdata=%h done=%b cyc=%0d bmw0=%h bmw95=%h; want kind=%0d addr=%h wdata=%h done=%b cyc=%0d bmw0=%h bmw95=%h",
                             monKind, monAddr, mem_wdata, done, cycleCnt, wbm_data[15:0], wbm_data[1535:1520],
                             monExp.kind, monExp.addr, monExp.data, monExp.done, monExp.cyc,
                             monExp.bm[15:0], monExp.bm[1535:1520]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p;
        rst       = 1'b1;
        start_ld  = 1'b0;
        start_st  = 1'b0;
        bm_sel    = 2'd0;
        base_addr = 16'h0000;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < BM_WORDS; i++) begin
                bmFile[r][i*16 +: 16] = (r == 1) ? 16'(i) : (16'hA000 + 16'(r * 256 + i));
            end
        end

        repeat (2) @(negedge clk);
        checkOutput("rstCtl", {27'd0, busy, done, mem_en, mem_wr, wbm_en}, 32'd0);
        checkOutput("rstMemAddr", {16'd0, mem_addr}, 32'd0);
        checkOutput("rstWdata", {16'd0, mem_wdata}, 32'd0);
        checkOutput("rstWbmAddr", {30'd0, wbm_addr}, 32'd0);
        checkOutput("rstBuf", {31'd0, |wbm_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] load base=0x0200 sel=2");
        applyStimulus(1'b1, 1'b0, 2'd2, 16'h0200, p);
        checkOutput("ldBusy", {31'd0, busy}, 32'd1);
        waitIdle(p, 98, "ld");

        $display("[TB] store base=0x0040 sel=1");
        applyStimulus(1'b0, 1'b1, 2'd1, 16'h0040, p);
        checkOutput("stBusy", {31'd0, busy}, 32'd1);
        waitIdle(p, 96, "st");

        $display("[TB] load wrap base=0xFFF0 sel=3");
        applyStimulus(1'b1, 1'b0, 2'd3, 16'hFFF0, p);
        waitIdle(p, 98, "wrap");

        $display("[TB] start_ld and start_st together");
        applyStimulus(1'b1, 1'b1, 2'd0, 16'h0100, p);
        waitIdle(p, 98, "both");

        $display("[TB] start_st pulse during load");
        applyStimulus(1'b1, 1'b0, 2'd2, 16'h0A00, p);
        while (cycleCnt < p + 40) @(negedge clk);
        start_st  = 1'b1;
        bm_sel    = 2'd1;
        base_addr = 16'h7777;
        @(negedge clk);
        start_st = 1'b0;
        waitIdle(p, 98, "ignSt");

        $display("[TB] reset in the middle of a load");
        applyStimulus(1'b1, 1'b0, 2'd1, 16'h0300, p);
        while (cycleCnt < p + 50) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midRstCtl", {27'd0, busy, done, mem_en, mem_wr, wbm_en}, 32'd0);
        checkOutput("midRstAddr", {16'd0, mem_addr}, 32'd0);
        checkOutput("midRstWbmAddr", {30'd0, wbm_addr}, 32'd0);
        checkOutput("midRstBuf", {31'd0, |wbm_data}, 32'd0);
        checkOutput("midRstPending", expQ.size(), 32'd47);
        expQ.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        $display("[TB] load after reset base=0x0800 sel=0");
        applyStimulus(1'b1, 1'b0, 2'd0, 16'h0800, p);
        waitIdle(p, 98, "reld");

        repeat (3) @(negedge clk);
        checkOutput("finalQ", expQ.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/bm_xfer_seq.md
BM_XFER_SEQ -- requirements
Module: bm_xfer_seq

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high. Ports: clk (in, 1, rising-edge clock) and rst (in, 1, async active-high reset).
REQ-002 SHALL have start_ld (in, 1): request to load a bitmap from data memory into a bitmap register (LDB).
REQ-003 SHALL have start_st (in, 1): request to store a bitmap register to data memory (STB).
REQ-004 SHALL have bm_sel (in, 2): target or source bitmap register index, sampled on an accepted start.
REQ-005 SHALL have base_addr (in, 16): data-memory word address of bitmap word 0, sampled on an accepted start.
REQ-006 SHALL have mem_addr (out, 16), mem_en (out, 1), mem_wr (out, 1), mem_wdata (out, 16) and mem_rdata (in, 16) as the data-memory port; read data is valid the cycle after the request.
REQ-007 SHALL have rbm_addr (out, 2) and rbm_data (in, 1536) as the bitmap register read port, combinational read.
REQ-008 SHALL have wbm_addr (out, 2), wbm_data (out, 1536) and wbm_en (out, 1) as the bitmap register write port.
REQ-009 SHALL have busy (out, 1): pipeline stall request, high whenever the block is not idle.
REQ-010 SHALL have done (out, 1): one-cycle completion pulse.

Function
REQ-011 SHALL implement the states IDLE, LD, LD_LAST, WR_BM and ST.
REQ-012 SHALL accept a start only in IDLE; a start while busy SHALL be ignored, with no queueing.
REQ-013 SHALL give start_ld priority when start_ld and start_st are both high in IDLE; the store request SHALL be dropped.
REQ-014 SHALL drive rbm_addr = bm_sel in IDLE and, on an accepted start_st, capture rbm_data into the 1536-bit transfer buffer, latch base_addr and bm_sel, and enter ST.
REQ-015 SHALL, on an accepted start_ld, latch base_addr and bm_sel, clear the word counter (7 bits, range 0..95), and enter LD.
REQ-016 SHALL, in LD, assert mem_en=1, mem_wr=0 and mem_addr = base+cnt each cycle, and increment cnt; after the cnt=95 issue it SHALL go to LD_LAST.
REQ-017 SHALL, in LD (from the second cycle on) and in LD_LAST, write mem_rdata into buffer bits [16k+15:16k], where k = the word index issued the previous cycle; word 0 SHALL land in bits [15:0].
REQ-018 SHALL, in WR_BM, hold wbm_en=1, wbm_addr = latched bm_sel, wbm_data = buffer, and done=1 for exactly one cycle, then return to IDLE.
REQ-019 SHALL, in ST, assert mem_en=1, mem_wr=1, mem_addr = base+cnt and mem_wdata = buffer[16cnt+15:16cnt] each cycle; on the cnt=95 cycle done=1, and the next state is IDLE.
REQ-020 SHALL take 98 cycles from the accepting edge to done for a load and 96 cycles for a store; busy SHALL fall the cycle after done.
REQ-021 SHALL compute addresses base+cnt modulo 2^16, so 0xFFFF SHALL wrap to 0x0000.
REQ-022 SHALL hold mem_en, mem_wr, wbm_en and done at 0 in every state not listed above; wbm_en SHALL never assert during ST.

Reset
REQ-023 SHALL, on rst, immediately force state=IDLE, cnt=0, latched base/sel=0 and buffer=0, and drive busy, done, mem_en, mem_wr and wbm_en to 0, with mem_addr, mem_wdata and wbm_addr at 0.
REQ-024 SHALL abort any in-flight transfer when rst is asserted mid-operation: no partial wbm_en, no further memory writes, and no done pulse.

Structure
REQ-025 SHALL place the state encoding, BM_WORDS=96, BM_WIDTH=1536 and WORD_W=16 in the shared package bm_seq_pkg.
REQ-026 SHALL factor the transfer buffer with its indexed word write and word read into one sub-module, bm_xfer_buf; the FSM and counter SHALL stay in bm_xfer_seq.

Verification
REQ-027 Load: memory word i = 0x1000+i, base=0x0200, start_ld, bm_sel=2 -> reads 0x0200..0x025F on consecutive cycles; wbm_en for one cycle at cycle 98 with wbm_addr=2, wbm_data[15:0]=0x1000 and wbm_data[1535:1520]=0x105F; done in the same cycle.
REQ-028 Store: rbm_data = 96 words, word i = i, base=0x0040, start_st -> writes 0x0040..0x009F with data 0..95; done on the cycle 0x009F is written; busy low the next cycle.
REQ-029 Wrap: load with base=0xFFF0 -> mem_addr sequence 0xFFF0..0xFFFF, then 0x0000..0x004F.
REQ-030 Contention: start_ld and start_st high together -> load only; start_st pulsed during a load at cycle 40 -> ignored, and no memory writes occur.
REQ-031 Reset mid-load: assert rst at cycle 50 of a load -> all outputs 0 immediately; wbm_en and done are never seen; a new load after release completes normally.
